// File: rtl/reg_file_ctrl.sv
// rtl/reg_file_ctrl.sv - operand fetch / writeback sequencer for a single-port register file
// Optional feature: define RF_BYPASS_EN to forward HOLD-state writebacks into matching held operands.

module reg_file_ctrl #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  rs1_en,
    input  logic                  rs2_en,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [REG_WIDTH-1:0]  wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [REG_WIDTH-1:0]  rs1_data,
    output logic [REG_WIDTH-1:0]  rs2_data,
    output logic                  rf_read_en,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [REG_WIDTH-1:0]  rf_wr_data,
    input  logic                  rf_rd_data_val,
    input  logic [REG_WIDTH-1:0]  rf_rd_data
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP, HOLD} state_t;

    state_t                  state;
    logic                    rs1_en_q;
    logic                    rs2_en_q;
    logic [ADDR_WIDTH-1:0]   rs1_addr_q;
    logic [ADDR_WIDTH-1:0]   rs2_addr_q;
    logic [REG_WIDTH-1:0]    rs1_q;
    logic [REG_WIDTH-1:0]    rs2_q;
    logic                    rs1_rd;
    logic                    rs2_rd;

    // Register 0 is never read from the array; its operand is forced to zero by the capture path.
    assign rs1_rd = rs1_en_q && (rs1_addr_q != '0);
    assign rs2_rd = rs2_en_q && (rs2_addr_q != '0);

    // Port outputs are gated by rst_n so nothing reaches the register file during reset.
    always_comb begin
        req_ready   = 1'b0;
        wb_ready    = 1'b0;
        rf_read_en  = 1'b0;
        rf_write_en = 1'b0;
        rf_addr     = '0;
        rf_wr_data  = '0;
        if (rst_n) begin
            case (state)
                IDLE, HOLD: begin
                    if (wb_valid) begin
                        wb_ready = 1'b1;
                        if (wb_addr != '0) begin
                            rf_write_en = 1'b1;
                            rf_addr     = wb_addr;
                            rf_wr_data  = wb_data;
                        end
                    end else if (req_valid && state == IDLE) begin
                        req_ready = 1'b1;
                    end
                end
                RD1: begin
                    if (rs1_rd) begin
                        rf_read_en = 1'b1;
                        rf_addr    = rs1_addr_q;
                    end
                end
                RD2: begin
                    if (rs2_rd) begin
                        rf_read_en = 1'b1;
                        rf_addr    = rs2_addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_valid = rst_n && (state == HOLD);
    assign rs1_data = rst_n ? rs1_q : '0;
    assign rs2_data = rst_n ? rs2_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs1_en_q   <= 1'b0;
            rs2_en_q   <= 1'b0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!wb_valid && req_valid) begin
                        rs1_en_q   <= rs1_en;
                        rs2_en_q   <= rs2_en;
                        rs1_addr_q <= rs1_addr;
                        rs2_addr_q <= rs2_addr;
                        state      <= RD1;
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    rs1_q <= rf_rd_data_val ? rf_rd_data : '0;
                    state <= CAP;
                end
                CAP: begin
                    rs2_q <= rf_rd_data_val ? rf_rd_data : '0;
                    state <= HOLD;
                end
                HOLD: begin
`ifdef RF_BYPASS_EN
                    if (wb_valid && wb_addr != '0) begin
                        if (rs1_en_q && wb_addr == rs1_addr_q) rs1_q <= wb_data;
                        if (rs2_en_q && wb_addr == rs2_addr_q) rs2_q <= wb_data;
                    end
`endif
                    if (op_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb/tb_reg_file_ctrl.sv - directed bench for reg_file_ctrl with a behavioural register file

module tb_reg_file_ctrl;

    localparam int RW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic          rs1_en, rs2_en;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [RW-1:0] wb_data;
    logic          op_valid, op_ready;
    logic [RW-1:0] rs1_data, rs2_data;
    logic          rf_read_en, rf_write_en;
    logic [AW-1:0] rf_addr;
    logic [RW-1:0] rf_wr_data;
    logic          rf_rd_data_val = 1'b0;
    logic [RW-1:0] rf_rd_data = '0;

    logic [RW-1:0] mem [0:(1<<AW)-1];
    int            tests = 0;
    int            fails = 0;
    int            rd_cnt = 0;
    int            rd_base;
    int            both_en = 0;
    int            wr_r0 = 0;
    logic [RW-1:0] exp_rs2;

    always #5 clk = ~clk;

    reg_file_ctrl #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data_val(rf_rd_data_val), .rf_rd_data(rf_rd_data)
    );

    // Register file: one-cycle read latency, write visible to reads issued later.
    always @(posedge clk) begin
        if (rf_write_en) mem[rf_addr] <= rf_wr_data;
        rf_rd_data_val <= rf_read_en;
        if (rf_read_en) rf_rd_data <= mem[rf_addr];
        if (rf_read_en) rd_cnt <= rd_cnt + 1;
        if (rf_read_en && rf_write_en) both_en <= both_en + 1;
        if (rf_write_en && rf_addr == '0) wr_r0 <= wr_r0 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'hBAD0_0000 + i;
        rst_n = 1'b0; req_valid = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; rs1_addr = 4'd1; rs2_addr = 4'd2;
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h1; op_ready = 1'b0;
        tick(); #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_wb_ready", wb_ready, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_rs2", rs2_data, 32'h0);
        chk("rst_wr_en", rf_write_en, 1'b0);
        chk("rst_rd_en", rf_read_en, 1'b0);
        chk("rst_addr", rf_addr, 4'd0);
        chk("rst_wdata", rf_wr_data, 32'h0);

        // Writeback r5, then request rs1=5 rs2=0
        tick();
        rst_n = 1'b1; req_valid = 1'b0; wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF; #1;
        chk("wb5_ready", wb_ready, 1'b1);
        chk("wb5_wr_en", rf_write_en, 1'b1);
        chk("wb5_addr", rf_addr, 4'd5);
        chk("wb5_data", rf_wr_data, 32'hDEADBEEF);
        tick();
        wb_valid = 1'b0; req_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 4'd5; rs2_en = 1'b1; rs2_addr = 4'd0; #1;
        chk("t1_req_ready", req_ready, 1'b1);
        tick(); req_valid = 1'b0; #1;
        chk("t1_rd1_en", rf_read_en, 1'b1);
        chk("t1_rd1_addr", rf_addr, 4'd5);
        chk("t1_rd1_req_ready", req_ready, 1'b0);
        tick(); #1;
        chk("t1_rd2_no_read", rf_read_en, 1'b0);
        chk("t1_rd2_wb_ready", wb_ready, 1'b0);
        tick(); #1;
        chk("t1_cap_op_valid", op_valid, 1'b0);
        tick(); op_ready = 1'b1; #1;
        chk("t1_op_valid", op_valid, 1'b1);
        chk("t1_rs1", rs1_data, 32'hDEADBEEF);
        chk("t1_rs2", rs2_data, 32'h0);
        tick(); op_ready = 1'b0; #1;
        chk("t1_idle_op_valid", op_valid, 1'b0);

        // wb and req together: write first; rs1 disabled, rs2=3
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h12345678;
        req_valid = 1'b1; rs1_en = 1'b0; rs1_addr = 4'd5; rs2_en = 1'b1; rs2_addr = 4'd3; #1;
        chk("t2_wb_ready", wb_ready, 1'b1);
        chk("t2_req_blocked", req_ready, 1'b0);
        chk("t2_wr_en", rf_write_en, 1'b1);
        tick(); wb_valid = 1'b0; #1;
        chk("t2_req_ready", req_ready, 1'b1);
        rd_base = rd_cnt;
        tick(); req_valid = 1'b0; #1;
        chk("t2_rd1_no_read", rf_read_en, 1'b0);
        tick(); #1;
        chk("t2_rd2_en", rf_read_en, 1'b1);
        chk("t2_rd2_addr", rf_addr, 4'd3);
        tick(); tick(); #1;
        chk("t2_op_valid", op_valid, 1'b1);
        chk("t2_rs1", rs1_data, 32'h0);
        chk("t2_rs2", rs2_data, 32'h12345678);
        chk("t2_read_pulses", rd_cnt - rd_base, 1);
        op_ready = 1'b1;
        tick(); op_ready = 1'b0;

        // Write to r0 is suppressed; read of r0 yields zero
        wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFFFFFF; #1;
        chk("t3_wb_ready", wb_ready, 1'b1);
        chk("t3_wr_suppressed", rf_write_en, 1'b0);
        tick(); wb_valid = 1'b0; req_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 4'd0; rs2_en = 1'b1; rs2_addr = 4'd5;
        tick(); req_valid = 1'b0; #1;
        chk("t3_rd1_no_read", rf_read_en, 1'b0);
        tick(); tick(); tick(); #1;
        chk("t3_op_valid", op_valid, 1'b1);
        chk("t3_rs1", rs1_data, 32'h0);
        chk("t3_rs2", rs2_data, 32'hDEADBEEF);
        op_ready = 1'b1;
        tick(); op_ready = 1'b0;

        // HOLD with writeback to a held operand register
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h11111111;
        tick(); wb_valid = 1'b0; req_valid = 1'b1; rs1_en = 1'b1; rs1_addr = 4'd3; rs2_en = 1'b1; rs2_addr = 4'd7;
        tick(); req_valid = 1'b0;
        tick(); tick(); tick(); #1;
        chk("t4_op_valid", op_valid, 1'b1);
        chk("t4_rs2_before", rs2_data, 32'h11111111);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'hA5A5A5A5; #1;
        chk("t4_hold_wb_ready", wb_ready, 1'b1);
        chk("t4_hold_wr_en", rf_write_en, 1'b1);
        tick(); wb_valid = 1'b0; #1;
`ifdef RF_BYPASS_EN
        exp_rs2 = 32'hA5A5A5A5;
`else
        exp_rs2 = 32'h11111111;
`endif
        chk("t4_hold_op_valid", op_valid, 1'b1);
        chk("t4_rs2_after", rs2_data, exp_rs2);
        chk("t4_rs1_after", rs1_data, 32'h12345678);
        tick(); op_ready = 1'b1;
        tick(); op_ready = 1'b0; #1;
        chk("t4_idle", op_valid, 1'b0);

        // Reset during RD2, then a clean request
        req_valid = 1'b1; rs1_addr = 4'd7; rs2_addr = 4'd3;
        tick(); req_valid = 1'b0;
        tick(); rst_n = 1'b0; #1;
        chk("t5_rst_rd_en", rf_read_en, 1'b0);
        tick(); rst_n = 1'b1; #1;
        chk("t5_op_valid", op_valid, 1'b0);
        chk("t5_rs1_cleared", rs1_data, 32'h0);
        chk("t5_rs2_cleared", rs2_data, 32'h0);
        req_valid = 1'b1; #1;
        chk("t5_req_ready", req_ready, 1'b1);
        tick(); req_valid = 1'b0;
        tick(); tick(); #1;
        chk("t5_cap_op_valid", op_valid, 1'b0);
        tick(); #1;
        chk("t5_op_valid_hold", op_valid, 1'b1);
        chk("t5_rs1", rs1_data, 32'hA5A5A5A5);
        chk("t5_rs2", rs2_data, 32'h12345678);
        op_ready = 1'b1;
        tick(); op_ready = 1'b0; #1;

        chk("never_both_en", both_en, 0);
        chk("never_write_r0", wr_r0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
